// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline control bundle, bubble constant and D->E beat states.
package pipe_ctrl_pkg;
  typedef struct packed {
    logic       alu_src;
    logic [3:0] alu_control;
    logic       mem_to_reg;
    logic       reg_write;
    logic       plus_one;
    logic       branch;
    logic       pcsrc;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
  typedef enum logic {BEAT1, BEAT2} de_state_t;
endpackage

// File: rtl/pipe_en_clr_reg.sv
// pipe_en_clr_reg: pipeline register with enable, sync clear and async active-low reset.
module pipe_en_clr_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/decode_execute_reg.sv
// decode_execute_reg: D->E pipeline register with stall/flush and two-beat PlusOne sequencing.
module decode_execute_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic              alu_src_d,
  input  logic              mem_to_reg_d,
  input  logic              reg_write_d,
  input  logic              plus_one_d,
  input  logic              branch_d,
  input  logic              pcsrc_d,
  input  logic [3:0]        alu_control_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] ext_imm_d,
  input  logic [RA_W-1:0]   wa3_d,
  input  logic [RA_W-1:0]   ra1_d,
  input  logic [RA_W-1:0]   ra2_d,
  input  logic              stall_e,
  input  logic              flush_e,
  output logic              valid_e,
  output logic              alu_src_e,
  output logic              mem_to_reg_e,
  output logic              reg_write_e,
  output logic              plus_one_e,
  output logic              branch_e,
  output logic              pcsrc_e,
  output logic [3:0]        alu_control_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] ext_imm_e,
  output logic [RA_W-1:0]   wa3_e,
  output logic [RA_W-1:0]   ra1_e,
  output logic [RA_W-1:0]   ra2_e,
  output logic              beat2_e,
  output logic              hold_d
);
  de_state_t state;
  ctrl_t     ctrl_d, ctrl_e;
  logic      reload, load, clr;
  assign ctrl_d = '{alu_src: alu_src_d, alu_control: alu_control_d, mem_to_reg: mem_to_reg_d,
                    reg_write: reg_write_d, plus_one: plus_one_d, branch: branch_d, pcsrc: pcsrc_d};
  assign hold_d = state == BEAT1 && valid_e && ctrl_e.plus_one && !flush_e;
  assign reload = hold_d && !stall_e;
  assign load   = !flush_e && !stall_e && !reload;
  assign clr    = flush_e || (load && !valid_d);
  // Beat 2 keeps every field except the immediate, which steps by one.
  pipe_en_clr_reg #(.W(DATA_W)) u_imm (
    .clk(clk), .rst_n(rst_n), .en(flush_e || !stall_e), .clr(clr),
    .d(reload ? ext_imm_e + DATA_W'(1) : ext_imm_d), .q(ext_imm_e)
  );
  pipe_en_clr_reg #(.W(2*DATA_W + 3*RA_W)) u_data (
    .clk(clk), .rst_n(rst_n), .en(flush_e || load), .clr(clr),
    .d({rd1_d, rd2_d, wa3_d, ra1_d, ra2_d}), .q({rd1_e, rd2_e, wa3_e, ra1_e, ra2_e})
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= BEAT1;
      ctrl_e  <= CTRL_BUBBLE;
      valid_e <= 1'b0;
      beat2_e <= 1'b0;
    end else if (flush_e) begin
      state   <= BEAT1;
      ctrl_e  <= CTRL_BUBBLE;
      valid_e <= 1'b0;
      beat2_e <= 1'b0;
    end else if (!stall_e) begin
      if (reload) begin
        state   <= BEAT2;
        beat2_e <= 1'b1;
      end else begin
        state   <= BEAT1;
        ctrl_e  <= valid_d ? ctrl_d : CTRL_BUBBLE;
        valid_e <= valid_d;
        beat2_e <= 1'b0;
      end
    end
  assign alu_src_e     = ctrl_e.alu_src;
  assign alu_control_e = ctrl_e.alu_control;
  assign mem_to_reg_e  = ctrl_e.mem_to_reg;
  assign reg_write_e   = ctrl_e.reg_write;
  assign plus_one_e    = ctrl_e.plus_one;
  assign branch_e      = ctrl_e.branch;
  assign pcsrc_e       = ctrl_e.pcsrc;
endmodule

// File: tb/tb_decode_execute_reg.sv
// tb_decode_execute_reg: directed scoreboard bench for the D->E register.
module tb_decode_execute_reg;
  import pipe_ctrl_pkg::*;
  typedef struct packed {
    ctrl_t       c;
    logic [31:0] rd1, rd2, imm;
    logic [3:0]  wa3, ra1, ra2;
  } ins_t;
  typedef struct packed {
    logic valid;
    ins_t i;
    logic beat2;
    logic hold;
  } obs_t;
  logic clk = 0, rst_n = 0;
  logic valid_d = 0, stall_e = 0, flush_e = 0;
  ins_t din = '0;
  logic valid_e, alu_src_e, mem_to_reg_e, reg_write_e, plus_one_e, branch_e, pcsrc_e, beat2_e, hold_d;
  logic [3:0] alu_control_e, wa3_e, ra1_e, ra2_e;
  logic [31:0] rd1_e, rd2_e, ext_imm_e;
  obs_t exp_q[$];
  string tag_q[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  decode_execute_reg dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d),
    .alu_src_d(din.c.alu_src), .mem_to_reg_d(din.c.mem_to_reg), .reg_write_d(din.c.reg_write),
    .plus_one_d(din.c.plus_one), .branch_d(din.c.branch), .pcsrc_d(din.c.pcsrc),
    .alu_control_d(din.c.alu_control), .rd1_d(din.rd1), .rd2_d(din.rd2), .ext_imm_d(din.imm),
    .wa3_d(din.wa3), .ra1_d(din.ra1), .ra2_d(din.ra2), .stall_e(stall_e), .flush_e(flush_e),
    .valid_e(valid_e), .alu_src_e(alu_src_e), .mem_to_reg_e(mem_to_reg_e), .reg_write_e(reg_write_e),
    .plus_one_e(plus_one_e), .branch_e(branch_e), .pcsrc_e(pcsrc_e), .alu_control_e(alu_control_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .ext_imm_e(ext_imm_e), .wa3_e(wa3_e), .ra1_e(ra1_e), .ra2_e(ra2_e),
    .beat2_e(beat2_e), .hold_d(hold_d)
  );
  localparam ctrl_t C_ADD = '{alu_src: 0, alu_control: 4'b0100, mem_to_reg: 0, reg_write: 1, plus_one: 0, branch: 0, pcsrc: 0};
  localparam ctrl_t C_STP = '{alu_src: 1, alu_control: 4'b0100, mem_to_reg: 0, reg_write: 0, plus_one: 1, branch: 0, pcsrc: 0};
  localparam ctrl_t C_JNK = '{alu_src: 1, alu_control: 4'b1111, mem_to_reg: 1, reg_write: 1, plus_one: 1, branch: 1, pcsrc: 1};
  localparam ins_t ADD1 = '{c: C_ADD, rd1: 5, rd2: 7, imm: 0, wa3: 3, ra1: 1, ra2: 2};
  localparam ins_t ADD2 = '{c: C_ADD, rd1: 9, rd2: 1, imm: 0, wa3: 6, ra1: 7, ra2: 8};
  localparam ins_t ADD3 = '{c: C_ADD, rd1: 1, rd2: 2, imm: 0, wa3: 1, ra1: 2, ra2: 3};
  localparam ins_t STP1 = '{c: C_STP, rd1: 32'h100, rd2: 32'hAB, imm: 32'h10, wa3: 0, ra1: 4, ra2: 5};
  localparam ins_t STPF = '{c: C_STP, rd1: 32'h200, rd2: 32'hCD, imm: 32'hFFFF_FFFF, wa3: 0, ra1: 9, ra2: 10};
  localparam ins_t STP2 = '{c: C_STP, rd1: 32'h300, rd2: 32'hEE, imm: 32'h20, wa3: 0, ra1: 11, ra2: 12};
  localparam ins_t JUNK = '{c: C_JNK, rd1: 32'h55, rd2: 32'h66, imm: 32'h77, wa3: 15, ra1: 14, ra2: 13};
  function automatic obs_t e_ins(ins_t i, logic [31:0] imm, logic b2, logic h);
    obs_t o;
    o.valid = 1; o.i = i; o.i.imm = imm; o.beat2 = b2; o.hold = h;
    return o;
  endfunction
  function automatic obs_t e_bub();
    return '0;
  endfunction
  // Inputs change just after the edge; the expectation is what the next negedge shows.
  task automatic step(string tag, logic r, logic v, ins_t i, logic st, logic fl, obs_t e);
    @(posedge clk);
    #1;
    rst_n = r; valid_d = v; din = i; stall_e = st; flush_e = fl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask
  always @(negedge clk) begin
    obs_t a, e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.valid = valid_e;
      a.i.c = '{alu_src: alu_src_e, alu_control: alu_control_e, mem_to_reg: mem_to_reg_e,
                reg_write: reg_write_e, plus_one: plus_one_e, branch: branch_e, pcsrc: pcsrc_e};
      a.i.rd1 = rd1_e; a.i.rd2 = rd2_e; a.i.imm = ext_imm_e;
      a.i.wa3 = wa3_e; a.i.ra1 = ra1_e; a.i.ra2 = ra2_e;
      a.beat2 = beat2_e; a.hold = hold_d;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", t, a, e);
      end
    end
  end
  initial begin
    step("reset",          0, 0, '0,   0, 0, e_bub());
    step("rst_release",    1, 1, ADD1, 0, 0, e_bub());
    step("add",            1, 1, STP1, 0, 0, e_ins(ADD1, 0, 0, 0));
    step("p1_beat1",       1, 1, ADD2, 0, 0, e_ins(STP1, 32'h10, 0, 1));
    step("p1_beat2",       1, 1, ADD2, 0, 0, e_ins(STP1, 32'h11, 1, 0));
    step("after_p1",       1, 1, STPF, 0, 0, e_ins(ADD2, 0, 0, 0));
    step("wrap_b1",        1, 1, STP2, 0, 0, e_ins(STPF, 32'hFFFF_FFFF, 0, 1));
    step("wrap_b2",        1, 1, STP2, 0, 0, e_ins(STPF, 32'h0, 1, 0));
    step("b2b_b1",         1, 1, ADD3, 1, 0, e_ins(STP2, 32'h20, 0, 1));
    step("stall1",         1, 1, ADD3, 1, 0, e_ins(STP2, 32'h20, 0, 1));
    step("stall2",         1, 1, ADD3, 0, 0, e_ins(STP2, 32'h20, 0, 1));
    step("b2_stall_flush", 1, 1, ADD3, 1, 1, e_ins(STP2, 32'h21, 1, 0));
    step("flush_bubble",   1, 0, JUNK, 0, 0, e_bub());
    step("invalid_bubble", 1, 1, ADD3, 0, 0, e_bub());
    step("add3",           1, 1, STP1, 0, 0, e_ins(ADD3, 0, 0, 0));
    step("flush_gates",    1, 1, ADD1, 0, 1, e_ins(STP1, 32'h10, 0, 0));
    step("flush_b1",       1, 1, STP1, 0, 0, e_bub());
    step("p1_again",       1, 1, ADD1, 0, 0, e_ins(STP1, 32'h10, 0, 1));
    step("reset_in_beat2", 0, 1, ADD1, 0, 0, e_bub());
    step("reset_hold",     1, 1, STP1, 0, 0, e_bub());
    step("post_rst_b1",    1, 0, '0,   0, 0, e_ins(STP1, 32'h10, 0, 1));
    step("post_rst_b2",    1, 0, '0,   0, 0, e_ins(STP1, 32'h11, 1, 0));
    step("idle",           1, 0, '0,   0, 0, e_bub());
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_execute_reg.md
# decode_execute_reg

Decode-to-execute pipeline register of the ARM pipelined datapath. It captures the decode-stage control bundle (from the control unit) and operand data each cycle, and supports stall, flush and bubble insertion. It owns the two-beat sequencing of store-plus-one (PlusOne) instructions: beat 1 uses the immediate as-is, beat 2 uses immediate+1, and decode is held for one cycle in between.

## Interface
- DATA_W, 32, operand/immediate width
- RA_W, 4, register-address width
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- valid_d  in  1  decode slot holds a real instruction
- alu_src_d, mem_to_reg_d, reg_write_d, plus_one_d, branch_d, pcsrc_d  in  1 each  decode control bits
- alu_control_d  in  4  ALU operation code
- rd1_d, rd2_d, ext_imm_d  in  DATA_W each  register operands, extended immediate
- wa3_d, ra1_d, ra2_d  in  RA_W each  destination/source register addresses
- stall_e  in  1  hold the execute register (hazard unit)
- flush_e  in  1  replace execute contents with a bubble
- *_e outputs  out  same widths as *_d  registered copies; valid_e is also an output
- beat2_e  out  1  execute holds beat 2 of a PlusOne instruction
- hold_d  out  1  combinational; upstream IF/ID must not advance this cycle

## Operation
- State machine: BEAT1 (normal, reset state) and BEAT2.
- In BEAT1 with no stall/flush, the register loads all *_d fields; beat2_e=0.
- hold_d = state==BEAT1 & valid_e & plus_one_e & ~flush_e. On that edge, the register reloads itself: ext_imm_e <= ext_imm_e+1 (mod 2^DATA_W, carry dropped), beat2_e <= 1, other fields unchanged, state -> BEAT2.
- In BEAT2 with no stall/flush, load *_d normally, state -> BEAT1, beat2_e <= 0.
- Priority per edge: flush_e > stall_e > PlusOne reload > normal load.
- flush_e, in either state: bubble, state -> BEAT1.
- stall_e: all fields and state hold. hold_d is still computed from current contents; the hazard unit already stalls decode.
- Bubble: valid_e=0, and all control outputs 0, including alu_control_e=4'b0000. Data fields are don't-care; implementation clears them to 0.
- Loading with valid_d=0 is a bubble. Undriven/z control from decode is never forwarded.
- reg_write_e, mem_to_reg_e, branch_e and pcsrc_e are 0 whenever valid_e=0.

## Timing
- Latency: 1 cycle D -> E. A PlusOne instruction occupies E for 2 cycles (3 if stalled once, etc.).
- Reset (async assert, sync release): every output is 0, state=BEAT1, hold_d=0.
- Reset during BEAT2 aborts the second beat. No partial state survives.
- Flush in the same cycle as hold_d=1: hold_d is 0 (gated by ~flush_e), bubble loads, decode advances.
- Back-to-back PlusOne instructions: BEAT2 loads the next PlusOne, then the BEAT1 hold repeats. No gap beyond the inherent beat.

## Structure
- Shared package pipe_ctrl_pkg: ctrl_t packed struct (alu_src, alu_control[3:0], mem_to_reg, reg_write, plus_one, branch, pcsrc), constant CTRL_BUBBLE, state enum de_state_t {BEAT1, BEAT2}.
- ALU opcode constants remain in the existing ALU parameter header. This block only passes them through.
- One sub-module: pipe_en_clr_reg (parameterised width; enable, synchronous clear, async active-low reset), instantiated for the data fields. The control bundle and FSM are local.

## Test plan
- Reset mid-run: assert rst_n=0 asynchronously between edges -> all outputs 0 immediately, state BEAT1.
- ADD decode (alu_control_d=ADD, reg_write_d=1, rd1_d=5, rd2_d=7, valid_d=1) -> next cycle *_e match, valid_e=1, hold_d=0.
- PlusOne store, ext_imm_d=0x10 -> cycle 1: ext_imm_e=0x10, hold_d=1. Cycle 2: ext_imm_e=0x11, beat2_e=1, hold_d=0. Cycle 3: next instruction.
- PlusOne with ext_imm_d=0xFFFFFFFF -> beat 2 ext_imm_e=0x00000000, no other field changes.
- stall_e=1 for 2 cycles during beat 1 -> contents and hold_d=1 frozen; beat 2 follows release.
- flush_e and stall_e together during BEAT2 -> bubble (valid_e=0, reg_write_e=0, alu_control_e=0), state BEAT1. Then valid_d=0 input -> bubble persists.
